ra_pq_p: RTL and testbench

Parametrised register-array priority queue. It holds up to DEPTH key/value entries in a sorted register array and always presents the best entry at the head. Supported operations are enqueue, dequeue and a combined replace (dequeue plus enqueue in one operation), with selectable min-first or max-first ordering. Ordering among equal keys is stable. It replaces the fixed-width 16-bit queue behind the board wrapper and is instantiated by that wrapper and by future scheduler blocks.

---
 rtl/ra_pq_p.sv | 230 +++++++++++++++++++++++
 tb/tb_ra_pq_p.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ra_pq_p.sv
// ra_pq_p -- register-array priority queue.
//
// Holds up to DEPTH {key, value} entries in a sorted register array with the
// best entry always at slot 0. Supports enqueue, dequeue and replace
// (dequeue + enqueue in one operation). Ties are kept in arrival order.
// Each accepted operation takes two cycles: the request and the per-slot
// compare vector are captured on the accept edge, and the array is rewritten
// on the following edge.
//
// Parameters:
//   KW        key width
//   VW        value width
//   DEPTH     number of entries (>= 2)
//   MIN_FIRST 1: smallest key at head, 0: largest key at head
//
// Ports:
//   clk    clock, rising edge
//   rst_n  asynchronous active-low reset, clears all state
//   enq    enqueue request (sampled when busy=0)
//   deq    dequeue request (sampled when busy=0)
//   kv_in  {key, value} to enqueue
//   kv_out {key, value} of the head entry, 0 when empty
//   empty  count == 0
//   full   count == DEPTH
//   busy   operation in progress, requests ignored
//   count  number of valid entries
//   ovf    one-cycle pulse: enqueue-only request while full (dropped)
//   udf    one-cycle pulse: dequeue request while empty
module ra_pq_p #(
    parameter int KW        = 8,
    parameter int VW        = 8,
    parameter int DEPTH     = 8,
    parameter int MIN_FIRST = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       enq,
    input  logic                       deq,
    input  logic [KW+VW-1:0]           kv_in,
    output logic [KW+VW-1:0]           kv_out,
    output logic                       empty,
    output logic                       full,
    output logic                       busy,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       ovf,
    output logic                       udf
);

    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // True when key a should sit ahead of key b. Equal keys are never
    // better, which is what places a new key behind its equals.
    function automatic logic is_better(input logic [KW-1:0] a, input logic [KW-1:0] b);
        if (MIN_FIRST != 0) begin
            return a < b;
        end else begin
            return a > b;
        end
    endfunction

    state_t           state;
    logic [KW-1:0]    key_q [DEPTH];
    logic [VW-1:0]    val_q [DEPTH];
    logic [DEPTH-1:0] vld_q;

    // Captured operation
    logic             op_enq_p0;
    logic             op_deq_p0;
    logic [KW-1:0]    key_p0;
    logic [VW-1:0]    val_p0;
    logic [DEPTH-1:0] slot_p0;

    logic [KW-1:0]    in_key;
    logic [VW-1:0]    in_val;
    logic [DEPTH-1:0] slot_now;

    assign in_key = kv_in[KW+VW-1:VW];
    assign in_val = kv_in[VW-1:0];

    // slot_now[i]: the new item belongs at or before slot i. Because the
    // array is sorted and empty slots count as "worse", this vector is
    // monotone: zeros followed by ones.
    always_comb begin
        slot_now = '0;
        for (int i = 0; i < DEPTH; i++) begin
            slot_now[i] = !vld_q[i] || is_better(in_key, key_q[i]);
        end
    end

    assign kv_out = {key_q[0], val_q[0]};
    assign empty  = (count == '0);
    assign full   = (count == CNT_FULL);
    assign busy   = (state == SHIFT);

    // ---- stage p0 -> array update ----
    // src_*: array after the optional head removal; the compare vector is
    // shifted with it so the insertion point stays correct for a replace.
    logic [KW-1:0]    src_key [DEPTH];
    logic [VW-1:0]    src_val [DEPTH];
    logic [DEPTH-1:0] src_vld;
    logic [DEPTH-1:0] src_slot;

    always_comb begin
        src_key  = '{default: '0};
        src_val  = '{default: '0};
        src_vld  = '0;
        src_slot = '0;
        for (int i = 0; i < DEPTH-1; i++) begin
            src_key[i]  = op_deq_p0 ? key_q[i+1]   : key_q[i];
            src_val[i]  = op_deq_p0 ? val_q[i+1]   : val_q[i];
            src_vld[i]  = op_deq_p0 ? vld_q[i+1]   : vld_q[i];
            src_slot[i] = op_deq_p0 ? slot_p0[i+1] : slot_p0[i];
        end
        src_key[DEPTH-1]  = op_deq_p0 ? '0   : key_q[DEPTH-1];
        src_val[DEPTH-1]  = op_deq_p0 ? '0   : val_q[DEPTH-1];
        src_vld[DEPTH-1]  = op_deq_p0 ? 1'b0 : vld_q[DEPTH-1];
        src_slot[DEPTH-1] = op_deq_p0 ? 1'b1 : slot_p0[DEPTH-1];
    end

    // prv_*: the neighbour above each slot, used when entries move down.
    logic [KW-1:0]    prv_key [DEPTH];
    logic [VW-1:0]    prv_val [DEPTH];
    logic [DEPTH-1:0] prv_vld;
    logic [DEPTH-1:0] prv_slot;

    always_comb begin
        prv_key  = '{default: '0};
        prv_val  = '{default: '0};
        prv_vld  = '0;
        prv_slot = '0;
        for (int i = 1; i < DEPTH; i++) begin
            prv_key[i]  = src_key[i-1];
            prv_val[i]  = src_val[i-1];
            prv_vld[i]  = src_vld[i-1];
            prv_slot[i] = src_slot[i-1];
        end
    end

    logic             do_ins;
    logic [KW-1:0]    nxt_key [DEPTH];
    logic [VW-1:0]    nxt_val [DEPTH];
    logic [DEPTH-1:0] nxt_vld;
    logic [CW-1:0]    nxt_count;

    // A replace always has room since the head has already been removed.
    assign do_ins = op_enq_p0 && (op_deq_p0 || !full);

    always_comb begin
        nxt_key = '{default: '0};
        nxt_val = '{default: '0};
        nxt_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (do_ins && src_slot[i]) begin
                if (!prv_slot[i]) begin
                    nxt_key[i] = key_p0;
                    nxt_val[i] = val_p0;
                    nxt_vld[i] = 1'b1;
                end else begin
                    nxt_key[i] = prv_key[i];
                    nxt_val[i] = prv_val[i];
                    nxt_vld[i] = prv_vld[i];
                end
            end else begin
                nxt_key[i] = src_key[i];
                nxt_val[i] = src_val[i];
                nxt_vld[i] = src_vld[i];
            end
        end
    end

    always_comb begin
        case ({op_enq_p0, op_deq_p0})
            2'b11:   nxt_count = empty ? CNT_ONE : count;
            2'b01:   nxt_count = empty ? count : count - CNT_ONE;
            2'b10:   nxt_count = full ? count : count + CNT_ONE;
            default: nxt_count = count;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            key_q     <= '{default: '0};
            val_q     <= '{default: '0};
            vld_q     <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            udf       <= 1'b0;
            op_enq_p0 <= 1'b0;
            op_deq_p0 <= 1'b0;
            key_p0    <= '0;
            val_p0    <= '0;
            slot_p0   <= '0;
        end else begin
            ovf <= 1'b0;
            udf <= 1'b0;
            case (state)
                IDLE: begin
                    // ---- accept -> stage p0 ----
                    if (enq || deq) begin
                        op_enq_p0 <= enq;
                        op_deq_p0 <= deq;
                        key_p0    <= in_key;
                        val_p0    <= in_val;
                        slot_p0   <= slot_now;
                        ovf       <= enq && !deq && full;
                        udf       <= deq && empty;
                        state     <= SHIFT;
                    end
                end
                SHIFT: begin
                    key_q <= nxt_key;
                    val_q <= nxt_val;
                    vld_q <= nxt_vld;
                    count <= nxt_count;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ra_pq_p.sv
// Bench for ra_pq_p: a min-first and a max-first instance driven in lockstep,
// checked against sorted-queue reference models through a scoreboard.
module tb_ra_pq_p;

    localparam int KW    = 8;
    localparam int VW    = 8;
    localparam int DEPTH = 8;
    localparam int CW    = $clog2(DEPTH+1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          enq;
    logic          deq;
    logic [15:0]   kv_in;

    logic [15:0]   kv_out0, kv_out1;
    logic          empty0, empty1, full0, full1, busy0, busy1;
    logic          ovf0, ovf1, udf0, udf1;
    logic [CW-1:0] count0, count1;

    ra_pq_p #(.KW(KW), .VW(VW), .DEPTH(DEPTH), .MIN_FIRST(1)) u_min (
        .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kv_in(kv_in),
        .kv_out(kv_out0), .empty(empty0), .full(full0), .busy(busy0),
        .count(count0), .ovf(ovf0), .udf(udf0)
    );

    ra_pq_p #(.KW(KW), .VW(VW), .DEPTH(DEPTH), .MIN_FIRST(0)) u_max (
        .clk(clk), .rst_n(rst_n), .enq(enq), .deq(deq), .kv_in(kv_in),
        .kv_out(kv_out1), .empty(empty1), .full(full1), .busy(busy1),
        .count(count1), .ovf(ovf1), .udf(udf1)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference models: ordered lists of {key,value}, head at index 0.
    logic [15:0] mq0[$];
    logic [15:0] mq1[$];

    typedef struct packed {
        logic [1:0]         ovf;
        logic [1:0]         udf;
        logic [1:0][15:0]   kv;
        logic [1:0][CW-1:0] cnt;
    } exp_t;

    exp_t exp_q[$];

    function automatic bit better(input logic [7:0] a, input logic [7:0] b, input bit minf);
        return minf ? (a < b) : (a > b);
    endfunction

    // New item goes before the first entry it beats, i.e. after all equals.
    function automatic int ins_pos(input logic [15:0] q[$], input logic [7:0] k, input bit minf);
        for (int i = 0; i < q.size(); i++) begin
            if (better(k, q[i][15:8], minf)) return i;
        end
        return q.size();
    endfunction

    task automatic model_step(input bit e, input bit d, input logic [15:0] kv, output exp_t x);
        int p;
        x.ovf[0] = e && !d && (mq0.size() == DEPTH);
        x.udf[0] = d && (mq0.size() == 0);
        if (d && mq0.size() > 0) void'(mq0.pop_front());
        if (e && !x.ovf[0]) begin
            p = ins_pos(mq0, kv[15:8], 1'b1);
            mq0.insert(p, kv);
        end
        x.kv[0]  = (mq0.size() > 0) ? mq0[0] : 16'h0;
        x.cnt[0] = CW'(mq0.size());

        x.ovf[1] = e && !d && (mq1.size() == DEPTH);
        x.udf[1] = d && (mq1.size() == 0);
        if (d && mq1.size() > 0) void'(mq1.pop_front());
        if (e && !x.ovf[1]) begin
            p = ins_pos(mq1, kv[15:8], 1'b0);
            mq1.insert(p, kv);
        end
        x.kv[1]  = (mq1.size() > 0) ? mq1[0] : 16'h0;
        x.cnt[1] = CW'(mq1.size());
    endtask

    task automatic do_op(input bit e, input bit d, input logic [15:0] kv);
        exp_t x;
        @(negedge clk);
        enq = e; deq = d; kv_in = kv;
        model_step(e, d, kv, x);
        exp_q.push_back(x);
        @(negedge clk);
        enq = 1'b0; deq = 1'b0; kv_in = 16'($urandom);
    endtask

    // Enqueue, then keep a second enqueue asserted only during the busy cycle.
    task automatic do_op_poke(input logic [15:0] kv, input logic [15:0] poke);
        exp_t x;
        @(negedge clk);
        enq = 1'b1; deq = 1'b0; kv_in = kv;
        model_step(1'b1, 1'b0, kv, x);
        exp_q.push_back(x);
        @(negedge clk);
        enq = 1'b1; kv_in = poke;
        @(negedge clk);
        enq = 1'b0; kv_in = 16'h0;
    endtask

    // Monitor: on each busy cycle pop the expected result, check the pulses,
    // then check the settled state one cycle later.
    exp_t mx;
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && (busy0 || busy1)) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_op: busy=%0b/%0b with no request issued at %0t", busy0, busy1, $time);
                end else begin
                    mx = exp_q.pop_front();
                    chk("ovf_min", ovf0, mx.ovf[0]);
                    chk("udf_min", udf0, mx.udf[0]);
                    chk("ovf_max", ovf1, mx.ovf[1]);
                    chk("udf_max", udf1, mx.udf[1]);
                    @(negedge clk);
                    chk("kv_min",    kv_out0, mx.kv[0]);
                    chk("count_min", count0,  mx.cnt[0]);
                    chk("empty_min", empty0,  mx.cnt[0] == 0);
                    chk("full_min",  full0,   mx.cnt[0] == DEPTH);
                    chk("busy_min",  busy0,   1'b0);
                    chk("pulse_min", {ovf0, udf0}, 2'b00);
                    chk("kv_max",    kv_out1, mx.kv[1]);
                    chk("count_max", count1,  mx.cnt[1]);
                    chk("empty_max", empty1,  mx.cnt[1] == 0);
                    chk("full_max",  full1,   mx.cnt[1] == DEPTH);
                    chk("busy_max",  busy1,   1'b0);
                    chk("pulse_max", {ovf1, udf1}, 2'b00);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [7:0] sort_keys [8] = '{8'h8E, 8'hBB, 8'h99, 8'hAA, 8'h11, 8'h77, 8'h33, 8'hCC};
    logic [7:0] min_order [8] = '{8'h11, 8'h33, 8'h77, 8'h8E, 8'h99, 8'hAA, 8'hBB, 8'hCC};
    logic [7:0] max_order [8] = '{8'hCC, 8'hBB, 8'hAA, 8'h99, 8'h8E, 8'h77, 8'h33, 8'h11};

    initial begin
        rst_n = 1'b0; enq = 1'b0; deq = 1'b0; kv_in = 16'h0;
        repeat (10) @(negedge clk);
        chk("rst_empty", {empty0, empty1}, 2'b11);
        chk("rst_full",  {full0, full1},   2'b00);
        chk("rst_busy",  {busy0, busy1},   2'b00);
        chk("rst_count", {count0, count1}, '0);
        chk("rst_kv",    {kv_out0, kv_out1}, 32'h0);
        chk("rst_pulse", {ovf0, udf0, ovf1, udf1}, 4'b0000);
        rst_n = 1'b1;

        // Reset asserted in the middle of an enqueue
        @(negedge clk);
        enq = 1'b1; kv_in = 16'h5555;
        @(posedge clk);
        #2;
        rst_n = 1'b0; enq = 1'b0;
        #1;
        chk("midrst_busy",  busy0,  1'b0);
        chk("midrst_count", count0, '0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("midrst_count_after", count0, '0);
        chk("midrst_empty_after", empty0, 1'b1);
        chk("midrst_kv_after",    kv_out0, 16'h0);

        // Fill with the sort sequence
        for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, {sort_keys[i], sort_keys[i]});
        @(negedge clk);
        chk("sort_full",     full0, 1'b1);
        chk("sort_count",    count0, 8);
        chk("sort_head_min", kv_out0[15:8], 8'h11);
        chk("sort_head_max", kv_out1[15:8], 8'hCC);

        // Overflow: enqueue-only while full is dropped
        do_op(1'b1, 1'b0, 16'h0000);
        @(negedge clk);
        chk("ovf_head_min",  kv_out0[15:8], 8'h11);
        chk("ovf_count_min", count0, 8);

        // Replace while full
        do_op(1'b1, 1'b1, 16'h0505);
        @(negedge clk);
        chk("repl05_head_min", kv_out0[15:8], 8'h05);
        chk("repl05_count",    count0, 8);
        do_op(1'b1, 1'b1, 16'hFFFF);
        @(negedge clk);
        chk("replFF_head_min", kv_out0[15:8], 8'h33);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i == 7) chk("replFF_last_min", kv_out0[15:8], 8'hFF);
            do_op(1'b0, 1'b1, 16'h0);
        end

        // Underflow, then replace on empty, then replace with count==1
        do_op(1'b0, 1'b1, 16'h0);
        do_op(1'b1, 1'b1, 16'h4242);
        @(negedge clk);
        chk("repl_empty_count", count0, 1);
        do_op(1'b1, 1'b1, 16'h9191);
        @(negedge clk);
        chk("repl_one_head", kv_out0, 16'h9191);
        do_op(1'b0, 1'b1, 16'h0);

        // Dequeue order in both modes
        for (int i = 0; i < 8; i++) do_op(1'b1, 1'b0, {sort_keys[i], sort_keys[i]});
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("order_min", kv_out0[15:8], min_order[i]);
            chk("order_max", kv_out1[15:8], max_order[i]);
            do_op(1'b0, 1'b1, 16'h0);
        end
        @(negedge clk);
        chk("drained_empty", {empty0, empty1}, 2'b11);

        // Ties keep arrival order; a request during busy is ignored
        do_op(1'b1, 1'b0, 16'h4001);
        do_op_poke(16'h4002, 16'h1009);
        @(negedge clk);
        chk("tie_count", count0, 2);
        chk("tie_first", kv_out0[7:0], 8'h01);
        do_op(1'b0, 1'b1, 16'h0);
        @(negedge clk);
        chk("tie_second", kv_out0[7:0], 8'h02);
        do_op(1'b0, 1'b1, 16'h0);

        // Random mix with many tied keys
        for (int n = 0; n < 300; n++) begin
            int r;
            logic [7:0] k;
            r = $urandom_range(0, 5);
            k = 8'($urandom_range(0, 7)) << 5;
            do_op(r >= 2, r <= 2, {k, 8'($urandom)});
        end

        repeat (4) @(negedge clk);
        chk("pending_ops", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
